// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer
//   Byte-level write engine for a 4-bit HD44780-style character LCD.
//   One command/data byte is accepted per iValid/oReady handshake. The byte
//   goes out as two nibbles, upper nibble first. Each nibble has setup, an
//   enable pulse and hold. A gap follows the upper nibble, and a post-write
//   wait follows the whole byte.
//   When iNibbleOnly is set, only iData[7:4] is sent. The power-on init
//   sequence uses this mode.
//
//   Build option: define LCD_LONG_WAIT_EN to use CLEAR_GAP_CYCLES after the
//   clear/return-home commands (0x01..0x03, RS = 0, full byte) in place of
//   BYTE_GAP_CYCLES.
//
// Ports
//   Clock                    system clock (50 MHz)
//   Reset                    asynchronous active-low reset
//   iValid / oReady          request handshake (oReady = idle)
//   iData[7:0]               byte to write
//   iRegisterSelect          0 = command, 1 = data
//   iNibbleOnly              send the upper nibble only
//   oDone                    one-cycle pulse in the last post-write cycle
//   oLCD_Enabled             LCD E
//   oLCD_RegisterSelect      LCD RS
//   oLCD_ReadWrite           LCD R/W, tied to write
//   oLCD_StrataFlashControl  held high to keep the shared flash off the bus
//   oLCD_Data[3:0]           LCD DB[7:4]
//
// States
//   state    | meaning
//   IDLE     | waiting for a request, oReady high
//   HI_SETUP | upper nibble and RS on the pins, E low
//   HI_PULSE | E high for the upper nibble
//   HI_HOLD  | E low, upper nibble still driven
//   NIB_GAP  | pins parked between the two nibbles
//   LO_SETUP | lower nibble and RS on the pins, E low
//   LO_PULSE | E high for the lower nibble
//   LO_HOLD  | E low, lower nibble still driven
//   BYTE_GAP | post-write execution wait, pins parked

module lcd_byte_writer #(
  parameter int unsigned SETUP_CYCLES      = 2,
  parameter int unsigned PULSE_CYCLES      = 12,
  parameter int unsigned HOLD_CYCLES       = 1,
  parameter int unsigned NIBBLE_GAP_CYCLES = 50,
  parameter int unsigned BYTE_GAP_CYCLES   = 2000,
  parameter int unsigned CLEAR_GAP_CYCLES  = 82000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iValid,
  output logic       oReady,
  input  logic [7:0] iData,
  input  logic       iRegisterSelect,
  input  logic       iNibbleOnly,
  output logic       oDone,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic       oLCD_StrataFlashControl,
  output logic [3:0] oLCD_Data
);

  // A state lasts (load + 1) cycles. A zero-length setting still takes one cycle.
  function automatic logic [19:0] load_val(input int unsigned cycles);
    return (cycles == 0) ? 20'd0 : 20'(cycles - 1);
  endfunction

  localparam logic [19:0] SETUP_LD = load_val(SETUP_CYCLES);
  localparam logic [19:0] PULSE_LD = load_val(PULSE_CYCLES);
  localparam logic [19:0] HOLD_LD  = load_val(HOLD_CYCLES);
  localparam logic [19:0] NGAP_LD  = load_val(NIBBLE_GAP_CYCLES);
  localparam logic [19:0] BGAP_LD  = load_val(BYTE_GAP_CYCLES);
  localparam logic [19:0] CGAP_LD  = load_val(CLEAR_GAP_CYCLES);

  typedef enum logic [3:0] {
    IDLE, HI_SETUP, HI_PULSE, HI_HOLD, NIB_GAP,
    LO_SETUP, LO_PULSE, LO_HOLD, BYTE_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic        rs_q, rs_d;
  logic        nib_q, nib_d;
  logic        e_q, e_d;
  logic        lcd_rs_q, lcd_rs_d;
  logic [3:0]  data_q, data_d;
  logic        done_q, done_d;

  logic        tc;
  logic        long_wait;
  logic [19:0] gap_ld;
  logic        hi_phase, lo_phase;

  assign tc = (cnt_q == 20'd0);

`ifdef LCD_LONG_WAIT_EN
  assign long_wait = !rs_q && !nib_q &&
                     ((byte_q == 8'h01) || (byte_q == 8'h02) || (byte_q == 8'h03));
`else
  assign long_wait = 1'b0;
`endif

  assign gap_ld = long_wait ? CGAP_LD : BGAP_LD;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    byte_d   = byte_q;
    rs_d     = rs_q;
    nib_d    = nib_q;
    hi_phase = 1'b0;
    lo_phase = 1'b0;

    if (state_q != IDLE && !tc)
      cnt_d = cnt_q - 20'd1;

    case (state_q)
      IDLE: if (iValid) begin
        state_d = HI_SETUP;
        cnt_d   = SETUP_LD;
        byte_d  = iData;
        rs_d    = iRegisterSelect;
        nib_d   = iNibbleOnly;
      end
      HI_SETUP: if (tc) begin state_d = HI_PULSE; cnt_d = PULSE_LD; end
      HI_PULSE: if (tc) begin state_d = HI_HOLD;  cnt_d = HOLD_LD;  end
      HI_HOLD:  if (tc) begin
        if (nib_q) begin state_d = BYTE_GAP; cnt_d = gap_ld;  end
        else       begin state_d = NIB_GAP;  cnt_d = NGAP_LD; end
      end
      NIB_GAP:  if (tc) begin state_d = LO_SETUP; cnt_d = SETUP_LD; end
      LO_SETUP: if (tc) begin state_d = LO_PULSE; cnt_d = PULSE_LD; end
      LO_PULSE: if (tc) begin state_d = LO_HOLD;  cnt_d = HOLD_LD;  end
      LO_HOLD:  if (tc) begin state_d = BYTE_GAP; cnt_d = gap_ld;   end
      BYTE_GAP: if (tc) begin state_d = IDLE;     cnt_d = 20'd0;    end
      default:  begin state_d = IDLE; cnt_d = 20'd0; end
    endcase

    // Pin values are decoded from the next state, so the registered pins
    // change on the same edge as the state does.
    hi_phase = (state_d == HI_SETUP) || (state_d == HI_PULSE) || (state_d == HI_HOLD);
    lo_phase = (state_d == LO_SETUP) || (state_d == LO_PULSE) || (state_d == LO_HOLD);
  end

  assign e_d      = (state_d == HI_PULSE) || (state_d == LO_PULSE);
  assign data_d   = hi_phase ? byte_d[7:4] : (lo_phase ? byte_d[3:0] : 4'h0);
  assign lcd_rs_d = (hi_phase || lo_phase) ? rs_d : 1'b0;
  assign done_d   = (state_d == BYTE_GAP) && (cnt_d == 20'd0);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      cnt_q    <= 20'd0;
      byte_q   <= 8'h00;
      rs_q     <= 1'b0;
      nib_q    <= 1'b0;
      e_q      <= 1'b0;
      lcd_rs_q <= 1'b0;
      data_q   <= 4'h0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      byte_q   <= byte_d;
      rs_q     <= rs_d;
      nib_q    <= nib_d;
      e_q      <= e_d;
      lcd_rs_q <= lcd_rs_d;
      data_q   <= data_d;
      done_q   <= done_d;
    end
  end

  assign oReady                  = (state_q == IDLE);
  assign oDone                   = done_q;
  assign oLCD_Enabled            = e_q;
  assign oLCD_RegisterSelect     = lcd_rs_q;
  assign oLCD_Data               = data_q;
  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Testbench for lcd_byte_writer.
// The driver queues each request as it issues it. A predictor runs at the
// observed handshake and turns each request into expected enable pulses,
// an expected oDone cycle and an expected oReady cycle. The monitor compares
// the pins against those queues.
// The clear-command wait is shortened here to keep the long-wait build short.
module tb_lcd_byte_writer;

  localparam int CLEAR_GAP = 8000;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       iValid = 1'b0;
  logic [7:0] iData = 8'h00;
  logic       iRegisterSelect = 1'b0;
  logic       iNibbleOnly = 1'b0;
  logic       oReady, oDone, oLCD_Enabled, oLCD_RegisterSelect;
  logic       oLCD_ReadWrite, oLCD_StrataFlashControl;
  logic [3:0] oLCD_Data;

  lcd_byte_writer #(
    .SETUP_CYCLES(2), .PULSE_CYCLES(12), .HOLD_CYCLES(1),
    .NIBBLE_GAP_CYCLES(50), .BYTE_GAP_CYCLES(2000), .CLEAR_GAP_CYCLES(CLEAR_GAP)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iValid(iValid), .oReady(oReady),
    .iData(iData), .iRegisterSelect(iRegisterSelect), .iNibbleOnly(iNibbleOnly),
    .oDone(oDone), .oLCD_Enabled(oLCD_Enabled),
    .oLCD_RegisterSelect(oLCD_RegisterSelect), .oLCD_ReadWrite(oLCD_ReadWrite),
    .oLCD_StrataFlashControl(oLCD_StrataFlashControl), .oLCD_Data(oLCD_Data)
  );

  always #10 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  typedef struct { logic [7:0] b; logic rs; logic nib; } req_t;
  typedef struct { logic [3:0] d; logic rs; int rise; } pulse_t;

  req_t   req_q[$];
  pulse_t pulse_q[$];
  int     done_q[$];
  int     ready_q[$];
  int     hs_log[$];

  function automatic void chk(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: got event, expected none (cycle %0d)", name, cyc);
  endfunction

  // Predictor: expected timing is counted from the handshake edge H.
  function automatic void predict(input req_t r, input int h);
    int gap, lat;
    pulse_t p;
    logic is_long;
    is_long = 1'b0;
`ifdef LCD_LONG_WAIT_EN
    is_long = !r.rs && !r.nib && (r.b == 8'h01 || r.b == 8'h02 || r.b == 8'h03);
`endif
    gap = is_long ? CLEAR_GAP : 2000;
    lat = r.nib ? (15 + gap) : (80 + gap);
    p.d = r.b[7:4]; p.rs = r.rs; p.rise = h + 2;
    pulse_q.push_back(p);
    if (!r.nib) begin
      p.d = r.b[3:0]; p.rise = h + 67;
      pulse_q.push_back(p);
    end
    done_q.push_back(h + lat - 1);
    ready_q.push_back(h + lat);
  endfunction

  // Monitor
  logic e_prev = 1'b0, rdy_prev = 1'b1, gap_chk = 1'b0;
  int   rise_cyc = 0;

  always @(negedge Clock) begin
    if (!Reset) begin
      pulse_q.delete(); done_q.delete(); ready_q.delete();
      e_prev = 1'b0; rdy_prev = 1'b1; gap_chk = 1'b0;
    end else begin
      if (gap_chk) begin
        chk("gap_data", oLCD_Data, 0);
        chk("gap_rs", oLCD_RegisterSelect, 0);
        gap_chk = 1'b0;
      end
      if (oLCD_Enabled && !e_prev) rise_cyc = cyc;
      if (!oLCD_Enabled && e_prev) begin
        if (pulse_q.size() == 0) fail_now("unexpected_e_pulse");
        else begin
          pulse_t p;
          p = pulse_q.pop_front();
          chk("nibble_data", oLCD_Data, p.d);
          chk("nibble_rs", oLCD_RegisterSelect, p.rs);
          chk("e_rise_cycle", rise_cyc, p.rise);
          chk("e_width", cyc - rise_cyc, 12);
        end
        chk("rw_low", oLCD_ReadWrite, 0);
        chk("sf_high", oLCD_StrataFlashControl, 1);
        gap_chk = 1'b1;
      end
      if (oDone) begin
        if (done_q.size() == 0) fail_now("unexpected_done");
        else chk("done_cycle", cyc, done_q.pop_front());
      end
      if (oReady && !rdy_prev) begin
        if (ready_q.size() == 0) fail_now("unexpected_ready");
        else chk("ready_cycle", cyc, ready_q.pop_front());
      end
      if (iValid && oReady) begin
        if (req_q.size() == 0) fail_now("handshake_without_request");
        else predict(req_q.pop_front(), cyc + 1);
        hs_log.push_back(cyc + 1);
      end
      e_prev   = oLCD_Enabled;
      rdy_prev = oReady;
    end
  end

  task automatic wait_hs();
    bit ok = 0;
    for (int i = 0; i < 100000; i++) begin
      @(negedge Clock);
      if (oReady) begin ok = 1; break; end
    end
    if (!ok) chk("handshake_timeout", 0, 1);
    @(posedge Clock); #1;
  endtask

  task automatic send(input logic [7:0] b, input logic rs, input logic nib);
    req_t r;
    r.b = b; r.rs = rs; r.nib = nib;
    @(posedge Clock); #1;
    req_q.push_back(r);
    iData = b; iRegisterSelect = rs; iNibbleOnly = nib; iValid = 1'b1;
    wait_hs();
    iValid = 1'b0;
    iData = ~b; iRegisterSelect = ~rs; iNibbleOnly = ~nib;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 100000; i++) begin
      @(negedge Clock);
      if (oReady) begin ok = 1; break; end
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, oReady, 1);
    chk({tag, "_done"}, oDone, 0);
    chk({tag, "_e"}, oLCD_Enabled, 0);
    chk({tag, "_rs"}, oLCD_RegisterSelect, 0);
    chk({tag, "_data"}, oLCD_Data, 0);
    chk({tag, "_rw"}, oLCD_ReadWrite, 0);
    chk({tag, "_sf"}, oLCD_StrataFlashControl, 1);
  endtask

  task automatic release_reset();
    @(posedge Clock); #1;
    Reset = 1'b1;
    @(negedge Clock);
    chk("ready_after_release", oReady, 1);
  endtask

  initial begin
    logic [7:0] seq [3];
    int e_seen;
    seq[0] = 8'h0C; seq[1] = 8'h06; seq[2] = 8'h80;

    repeat (3) @(negedge Clock);
    check_reset_outputs("por");
    release_reset();

    send(8'h28, 1'b0, 1'b0); wait_idle();
    send(8'h41, 1'b1, 1'b0); wait_idle();
    send(8'h30, 1'b0, 1'b1); wait_idle();

    // Back-to-back with iValid held; iData moves to the next byte mid-transaction.
    begin
      req_t r;
      int base;
      base = hs_log.size();
      @(posedge Clock); #1;
      r.b = seq[0]; r.rs = 1'b0; r.nib = 1'b0;
      req_q.push_back(r);
      iData = seq[0]; iRegisterSelect = 1'b0; iNibbleOnly = 1'b0; iValid = 1'b1;
      for (int k = 0; k < 3; k++) begin
        wait_hs();
        if (k < 2) begin
          r.b = seq[k+1];
          req_q.push_back(r);
          iData = seq[k+1];
        end else begin
          iValid = 1'b0;
          iData = 8'h55;
        end
      end
      wait_idle();
      chk("b2b_accepts", hs_log.size() - base, 3);
      if (hs_log.size() - base == 3) begin
        chk("b2b_spacing_1", hs_log[base+1] - hs_log[base], 2081);
        chk("b2b_spacing_2", hs_log[base+2] - hs_log[base+1], 2081);
      end
    end

    send(8'h01, 1'b0, 1'b0); wait_idle();

    // Reset during the gap between nibbles.
    send(8'h28, 1'b0, 1'b0);
    repeat (30) @(negedge Clock);
    #5 Reset = 1'b0;
    #1 check_reset_outputs("midop");
    repeat (2) @(negedge Clock);
    check_reset_outputs("midop_held");
    release_reset();

    // Reset during the upper-nibble enable pulse.
    send(8'h33, 1'b0, 1'b0);
    begin
      bit seen = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge Clock);
        if (oLCD_Enabled) begin seen = 1; break; end
      end
      chk("e_before_reset", seen, 1);
    end
    repeat (3) @(negedge Clock);
    #5 Reset = 1'b0;
    #1 chk("e_async_drop", oLCD_Enabled, 0);
    chk("data_async_clear", oLCD_Data, 0);
    repeat (3) @(posedge Clock);
    release_reset();
    e_seen = 0;
    repeat (2200) begin
      @(negedge Clock);
      if (oLCD_Enabled) e_seen++;
    end
    chk("no_pulse_after_reset", e_seen, 0);

    send(8'h0F, 1'b1, 1'b0); wait_idle();

    repeat (3) @(negedge Clock);
    chk("pending_pulses", pulse_q.size(), 0);
    chk("pending_done", done_q.size(), 0);
    chk("pending_ready", ready_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #(200000 * 20);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
